// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared defaults, buffer-occupancy encodings and the pop-credit helper
// for the FIFO read-side drain controller.
package fifo_drain_ctrl_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_TWO   = 2'd2;

  // A new pop is allowed only if every word already owed to the buffer still fits.
  function automatic logic has_credit(input occ_t occ, input logic inflight, input logic take);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, take};
    return (committed < 3'd2);
  endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry output buffer: accepts the word returning from FIFO storage
// and presents the oldest word at head.
module fifo_drain_skid
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output occ_t          occ
);

  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  occ_t          r_occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (push) begin
            r_head <= push_data;
            r_occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && !pop) begin
            r_tail <= push_data;
            r_occ  <= OCC_TWO;
          end else if (!push && pop) begin
            r_occ  <= OCC_EMPTY;
          end else if (push && pop) begin
            r_head <= push_data;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            r_head <= r_tail;
            r_occ  <= OCC_ONE;
          end
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

  assign head = r_head;
  assign occ  = r_occ;

  // The credit rule upstream guarantees a full buffer never sees a push.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && r_occ == OCC_TWO));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst)
    !(pop && r_occ == OCC_EMPTY));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// FIFO read-side drain controller: pop credit logic, in-flight tracking and
// valid/ready output. Define FIFO_DRAIN_CNT_EN to add the drained_cnt port.
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          empty,
  output logic          rd,
  input  logic [DW-1:0] fifo_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [AW:0]   drained_cnt
`endif
);

  logic r_inflight;
  occ_t w_occ;
  logic w_take;
  logic w_rd;

  assign out_valid = (w_occ != OCC_EMPTY);
  assign w_take    = out_valid & out_ready;

  // Gated by rst so no pop strobe leaks out while the FIFO pointers are clearing.
  assign w_rd = rst & en & ~empty & has_credit(w_occ, r_inflight, w_take);
  assign rd   = w_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
    end
  end

  fifo_drain_skid #(
    .DW(DW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (fifo_dout),
    .pop       (w_take),
    .head      (out_data),
    .occ       (w_occ)
  );

  assign busy = r_inflight | out_valid;

`ifdef FIFO_DRAIN_CNT_EN
  logic [AW:0] r_drained_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drained_cnt <= '0;
    end else if (w_take) begin
      r_drained_cnt <= r_drained_cnt + 1'b1;
    end
  end

  assign drained_cnt = r_drained_cnt;
`endif

endmodule
